// File: rtl/r_channel_router_pkg.sv
// Shared AXI read-channel definitions for the R-channel router.
package r_channel_router_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [3:0] TAG_M0 = 4'b0001;
    localparam logic [3:0] TAG_M1 = 4'b0010;
    localparam int NUM_SLAVES = 3;

endpackage

// File: rtl/r_channel_router_rr_arb3.sv
// Three-way round-robin pick: the search starts at the slave after last_gnt.
module rr_arb3 import r_channel_router_pkg::*; (
    input  logic [NUM_SLAVES-1:0] req,
    input  logic [1:0]            last_gnt,
    output logic [NUM_SLAVES-1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (last_gnt)
            2'd0: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd1: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/r_channel_router.sv
// Routes AXI R-channel beats from three slaves to two masters by the RID tag,
// locking onto one slave for the duration of a burst.
module r_channel_router import r_channel_router_pkg::*; #(
    parameter int ID_BITS   = 4,
    parameter int IDS_BITS  = 8,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDS_BITS-1:0]  RID_S0,
    input  logic [DATA_BITS-1:0] RDATA_S0,
    input  logic [1:0]           RRESP_S0,
    input  logic                 RLAST_S0,
    input  logic                 RVALID_S0,
    output logic                 RREADY_S0,
    input  logic [IDS_BITS-1:0]  RID_S1,
    input  logic [DATA_BITS-1:0] RDATA_S1,
    input  logic [1:0]           RRESP_S1,
    input  logic                 RLAST_S1,
    input  logic                 RVALID_S1,
    output logic                 RREADY_S1,
    input  logic [IDS_BITS-1:0]  RID_S2,
    input  logic [DATA_BITS-1:0] RDATA_S2,
    input  logic [1:0]           RRESP_S2,
    input  logic                 RLAST_S2,
    input  logic                 RVALID_S2,
    output logic                 RREADY_S2,
    output logic [ID_BITS-1:0]   RID_M0,
    output logic [DATA_BITS-1:0] RDATA_M0,
    output logic [1:0]           RRESP_M0,
    output logic                 RLAST_M0,
    output logic                 RVALID_M0,
    input  logic                 RREADY_M0,
    output logic [ID_BITS-1:0]   RID_M1,
    output logic [DATA_BITS-1:0] RDATA_M1,
    output logic [1:0]           RRESP_M1,
    output logic                 RLAST_M1,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M1
);

    state_e                state_q, state_d;
    logic [1:0]            last_gnt_q, last_gnt_d;
    logic [1:0]            lock_gnt_q, lock_gnt_d;
    logic [NUM_SLAVES-1:0] req, arb_gnt;
    logic [1:0]            g;
    logic                  g_valid;
    logic [IDS_BITS-1:0]   s_rid;
    logic [DATA_BITS-1:0]  s_data;
    logic [1:0]            s_resp;
    logic                  s_last, s_valid, s_ready;
    logic [3:0]            tag;
    logic                  to_m0, to_m1, active, hs, m0_sel, m1_sel;

    assign req = {RVALID_S2, RVALID_S1, RVALID_S0};

    rr_arb3 u_arb (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt      (arb_gnt)
    );

    // While locked the arbiter result is ignored so a burst is never split.
    always_comb begin
        g       = lock_gnt_q;
        g_valid = 1'b1;
        if (state_q == IDLE) begin
            g_valid = |arb_gnt;
            g       = arb_gnt[1] ? 2'd1 : (arb_gnt[2] ? 2'd2 : 2'd0);
        end
        case (g)
            2'd1: begin
                s_rid = RID_S1; s_data = RDATA_S1; s_resp = RRESP_S1;
                s_last = RLAST_S1; s_valid = RVALID_S1;
            end
            2'd2: begin
                s_rid = RID_S2; s_data = RDATA_S2; s_resp = RRESP_S2;
                s_last = RLAST_S2; s_valid = RVALID_S2;
            end
            default: begin
                s_rid = RID_S0; s_data = RDATA_S0; s_resp = RRESP_S0;
                s_last = RLAST_S0; s_valid = RVALID_S0;
            end
        endcase
    end

    assign tag     = s_rid[IDS_BITS-1 -: 4];
    assign to_m0   = (tag == TAG_M0);
    assign to_m1   = (tag == TAG_M1);
    assign active  = rst & g_valid;
    // Unmapped tags are sunk so a stray beat can never wedge the channel.
    assign s_ready = to_m0 ? RREADY_M0 : (to_m1 ? RREADY_M1 : 1'b1);
    assign hs      = active & s_valid & s_ready;
    assign m0_sel  = active & s_valid & to_m0;
    assign m1_sel  = active & s_valid & to_m1;

    assign RVALID_M0 = m0_sel;
    assign RID_M0    = m0_sel ? s_rid[ID_BITS-1:0] : '0;
    assign RDATA_M0  = m0_sel ? s_data : '0;
    assign RRESP_M0  = m0_sel ? s_resp : 2'b00;
    assign RLAST_M0  = m0_sel & s_last;

    assign RVALID_M1 = m1_sel;
    assign RID_M1    = m1_sel ? s_rid[ID_BITS-1:0] : '0;
    assign RDATA_M1  = m1_sel ? s_data : '0;
    assign RRESP_M1  = m1_sel ? s_resp : 2'b00;
    assign RLAST_M1  = m1_sel & s_last;

    assign RREADY_S0 = active & s_ready & (g == 2'd0);
    assign RREADY_S1 = active & s_ready & (g == 2'd1);
    assign RREADY_S2 = active & s_ready & (g == 2'd2);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        lock_gnt_d = lock_gnt_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    if (s_last) begin
                        last_gnt_d = g;
                    end else begin
                        lock_gnt_d = g;
                        state_d    = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (hs && s_last) begin
                    last_gnt_d = g;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_gnt_q <= 2'd2;
            lock_gnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            lock_gnt_q <= lock_gnt_d;
        end
    end

endmodule

// File: tb/tb_r_channel_router.sv
// Scoreboard bench for r_channel_router: slave BFMs feed beat queues, a monitor
// checks every accepted master beat and every discarded beat against expectations.
module tb_r_channel_router import r_channel_router_pkg::*; ;

    typedef struct packed {
        logic [7:0]  rid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk, rst;
    logic [7:0]  RID_S0, RID_S1, RID_S2;
    logic [31:0] RDATA_S0, RDATA_S1, RDATA_S2;
    logic [1:0]  RRESP_S0, RRESP_S1, RRESP_S2;
    logic        RLAST_S0, RLAST_S1, RLAST_S2;
    logic        RVALID_S0, RVALID_S1, RVALID_S2;
    logic        RREADY_S0, RREADY_S1, RREADY_S2;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;

    beat_t sq0[$], sq1[$], sq2[$];
    beat_t exp_m0[$], exp_m1[$], exp_disc[$];
    int checks = 0;
    int failures = 0;

    r_channel_router #(.ID_BITS(4), .IDS_BITS(8), .DATA_BITS(32)) dut (
        .clk(clk), .rst(rst),
        .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
        .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
        .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
        .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
        .RID_S2(RID_S2), .RDATA_S2(RDATA_S2), .RRESP_S2(RRESP_S2), .RLAST_S2(RLAST_S2),
        .RVALID_S2(RVALID_S2), .RREADY_S2(RREADY_S2),
        .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
        .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
        .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
        .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic pushSlave(input int s, input beat_t b);
        case (s)
            0:       sq0.push_back(b);
            1:       sq1.push_back(b);
            default: sq2.push_back(b);
        endcase
    endtask

    task automatic expectBeat(input beat_t b);
        beat_t e;
        e = b;
        e.rid = {4'h0, b.rid[3:0]};
        if (b.rid[7:4] == 4'h1)      exp_m0.push_back(e);
        else if (b.rid[7:4] == 4'h2) exp_m1.push_back(e);
        else                         exp_disc.push_back(b);
    endtask

    task automatic applyStimulus(input int s, input logic [7:0] rid, input logic [31:0] data,
                                 input logic [1:0] resp, input logic last);
        beat_t b;
        b = '{rid: rid, data: data, resp: resp, last: last};
        pushSlave(s, b);
        expectBeat(b);
    endtask

    // Slave BFMs: a beat leaves its queue only after the router accepted it.
    initial begin
        logic hs0, hs1, hs2;
        RID_S0 = '0; RDATA_S0 = '0; RRESP_S0 = '0; RLAST_S0 = 1'b0; RVALID_S0 = 1'b0;
        RID_S1 = '0; RDATA_S1 = '0; RRESP_S1 = '0; RLAST_S1 = 1'b0; RVALID_S1 = 1'b0;
        RID_S2 = '0; RDATA_S2 = '0; RRESP_S2 = '0; RLAST_S2 = 1'b0; RVALID_S2 = 1'b0;
        forever begin
            @(negedge clk);
            hs0 = RVALID_S0 & RREADY_S0;
            hs1 = RVALID_S1 & RREADY_S1;
            hs2 = RVALID_S2 & RREADY_S2;
            @(posedge clk);
            #1;
            if (hs0 && sq0.size() > 0) sq0.delete(0);
            if (hs1 && sq1.size() > 0) sq1.delete(0);
            if (hs2 && sq2.size() > 0) sq2.delete(0);
            if (sq0.size() > 0) begin
                RID_S0 = sq0[0].rid; RDATA_S0 = sq0[0].data; RRESP_S0 = sq0[0].resp;
                RLAST_S0 = sq0[0].last; RVALID_S0 = 1'b1;
            end else begin
                RID_S0 = '0; RDATA_S0 = '0; RRESP_S0 = '0; RLAST_S0 = 1'b0; RVALID_S0 = 1'b0;
            end
            if (sq1.size() > 0) begin
                RID_S1 = sq1[0].rid; RDATA_S1 = sq1[0].data; RRESP_S1 = sq1[0].resp;
                RLAST_S1 = sq1[0].last; RVALID_S1 = 1'b1;
            end else begin
                RID_S1 = '0; RDATA_S1 = '0; RRESP_S1 = '0; RLAST_S1 = 1'b0; RVALID_S1 = 1'b0;
            end
            if (sq2.size() > 0) begin
                RID_S2 = sq2[0].rid; RDATA_S2 = sq2[0].data; RRESP_S2 = sq2[0].resp;
                RLAST_S2 = sq2[0].last; RVALID_S2 = 1'b1;
            end else begin
                RID_S2 = '0; RDATA_S2 = '0; RRESP_S2 = '0; RLAST_S2 = 1'b0; RVALID_S2 = 1'b0;
            end
        end
    end

    task automatic checkDiscard(input logic [31:0] d);
        beat_t e;
        checkOutput("disc_mvalid", 64'({RVALID_M1, RVALID_M0}), 64'd0);
        if (exp_disc.size() == 0) begin
            checkOutput("disc_unexpected", 64'd1, 64'd0);
        end else begin
            e = exp_disc.pop_front();
            checkOutput("disc_data", 64'(d), 64'(e.data));
        end
    endtask

    // Monitor: compares every master handshake and every sunk beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (RVALID_M0 && RREADY_M0) begin
                if (exp_m0.size() == 0) checkOutput("m0_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_m0.pop_front();
                    checkOutput("m0_beat", 64'({RID_M0, RDATA_M0, RRESP_M0, RLAST_M0}),
                                64'({e.rid[3:0], e.data, e.resp, e.last}));
                end
            end
            if (RVALID_M1 && RREADY_M1) begin
                if (exp_m1.size() == 0) checkOutput("m1_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_m1.pop_front();
                    checkOutput("m1_beat", 64'({RID_M1, RDATA_M1, RRESP_M1, RLAST_M1}),
                                64'({e.rid[3:0], e.data, e.resp, e.last}));
                end
            end
            if (RVALID_S0 && RREADY_S0 && RID_S0[7:4] != 4'h1 && RID_S0[7:4] != 4'h2) checkDiscard(RDATA_S0);
            if (RVALID_S1 && RREADY_S1 && RID_S1[7:4] != 4'h1 && RID_S1[7:4] != 4'h2) checkDiscard(RDATA_S1);
            if (RVALID_S2 && RREADY_S2 && RID_S2[7:4] != 4'h1 && RID_S2[7:4] != 4'h2) checkDiscard(RDATA_S2);
        end
    end

    task automatic waitDrain(input string name);
        int cyc = 0;
        int remaining;
        remaining = sq0.size() + sq1.size() + sq2.size() + exp_m0.size() + exp_m1.size() + exp_disc.size();
        while (remaining != 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            remaining = sq0.size() + sq1.size() + sq2.size() + exp_m0.size() + exp_m1.size() + exp_disc.size();
        end
        checkOutput(name, 64'(remaining), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        RREADY_M0 = 1'b1;
        RREADY_M1 = 1'b1;

        // Reset with a pending beat: nothing may pass while rst is low.
        @(negedge clk);
        applyStimulus(0, 8'h11, 32'h1111_0000, 2'b00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rvalid_m0", 64'(RVALID_M0), 64'd0);
        checkOutput("rst_rready_s0", 64'(RREADY_S0), 64'd0);
        checkOutput("rst_rdata_m0", 64'(RDATA_M0), 64'd0);
        checkOutput("rst_state", 64'(dut.state_q), 64'(IDLE));
        checkOutput("rst_last_gnt", 64'(dut.last_gnt_q), 64'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        waitDrain("drain_init");

        // Single beat from S0 to M0, zero latency.
        applyStimulus(0, 8'h13, 32'hDEAD_BEEF, 2'b00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("single_rvalid_m0", 64'(RVALID_M0), 64'd1);
        checkOutput("single_rid_m0", 64'(RID_M0), 64'h3);
        checkOutput("single_rdata_m0", 64'(RDATA_M0), 64'hDEAD_BEEF);
        checkOutput("single_rready_s0", 64'(RREADY_S0), 64'd1);
        checkOutput("single_rvalid_m1", 64'(RVALID_M1), 64'd0);
        @(negedge clk);
        checkOutput("single_state", 64'(dut.state_q), 64'(IDLE));
        waitDrain("drain_single");

        // S1 burst to M1 with S0 becoming valid mid-burst.
        for (int b = 0; b < 4; b++)
            applyStimulus(1, 8'h25, 32'hB000_0000 + 32'(b), 2'b01, (b == 3));
        @(posedge clk);
        @(negedge clk);
        checkOutput("burst_b1_rvalid_m1", 64'(RVALID_M1), 64'd1);
        applyStimulus(0, 8'h16, 32'hA0A0_0001, 2'b00, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checkOutput("burst_rvalid_m1", 64'(RVALID_M1), 64'd1);
            checkOutput("burst_rdata_m1", 64'(RDATA_M1), 64'(32'hB000_0000 + 32'(i)));
            checkOutput("burst_rready_s0", 64'(RREADY_S0), 64'd0);
        end
        @(negedge clk);
        checkOutput("after_burst_rready_s0", 64'(RREADY_S0), 64'd1);
        checkOutput("after_burst_rvalid_m0", 64'(RVALID_M0), 64'd1);
        checkOutput("after_burst_rvalid_m1", 64'(RVALID_M1), 64'd0);
        waitDrain("drain_burst");

        // Round robin after reset: S0, S1, S2, S0.
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        pushSlave(0, '{rid: 8'h1A, data: 32'hC000_0001, resp: 2'b00, last: 1'b1});
        pushSlave(0, '{rid: 8'h1B, data: 32'hC000_0004, resp: 2'b00, last: 1'b1});
        pushSlave(1, '{rid: 8'h1C, data: 32'hC000_0002, resp: 2'b10, last: 1'b1});
        pushSlave(2, '{rid: 8'h1D, data: 32'hC000_0003, resp: 2'b00, last: 1'b1});
        expectBeat('{rid: 8'h1A, data: 32'hC000_0001, resp: 2'b00, last: 1'b1});
        expectBeat('{rid: 8'h1C, data: 32'hC000_0002, resp: 2'b10, last: 1'b1});
        expectBeat('{rid: 8'h1D, data: 32'hC000_0003, resp: 2'b00, last: 1'b1});
        expectBeat('{rid: 8'h1B, data: 32'hC000_0004, resp: 2'b00, last: 1'b1});
        @(posedge clk);
        @(negedge clk);
        checkOutput("rr_grant_1", 64'({RREADY_S2, RREADY_S1, RREADY_S0}), 64'b001);
        @(negedge clk);
        checkOutput("rr_grant_2", 64'({RREADY_S2, RREADY_S1, RREADY_S0}), 64'b010);
        @(negedge clk);
        checkOutput("rr_grant_3", 64'({RREADY_S2, RREADY_S1, RREADY_S0}), 64'b100);
        @(negedge clk);
        checkOutput("rr_grant_4", 64'({RREADY_S2, RREADY_S1, RREADY_S0}), 64'b001);
        waitDrain("drain_rr");

        // Unmapped tag on S2 is sunk.
        applyStimulus(2, 8'h45, 32'h5555_AAAA, 2'b00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("unmapped_rready_s2", 64'(RREADY_S2), 64'd1);
        checkOutput("unmapped_mvalid", 64'({RVALID_M1, RVALID_M0}), 64'd0);
        waitDrain("drain_unmapped");

        // M0 back-pressure for 3 cycles during beat 2.
        for (int b = 0; b < 4; b++)
            applyStimulus(0, 8'h1A, 32'hD000_0000 + 32'(b), 2'b00, (b == 3));
        @(posedge clk);
        @(posedge clk);
        #2 RREADY_M0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_rvalid_m0", 64'(RVALID_M0), 64'd1);
            checkOutput("stall_rdata_m0", 64'(RDATA_M0), 64'hD000_0001);
            checkOutput("stall_rready_s0", 64'(RREADY_S0), 64'd0);
        end
        @(posedge clk);
        #2 RREADY_M0 = 1'b1;
        waitDrain("drain_stall");

        // Reset during beat 2 of a burst abandons it.
        applyStimulus(0, 8'h1C, 32'hE000_0000, 2'b00, 1'b0);
        for (int b = 1; b < 4; b++)
            pushSlave(0, '{rid: 8'h1C, data: 32'hE000_0000 + 32'(b), resp: 2'b00, last: (b == 3)});
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_rvalid_m0", 64'(RVALID_M0), 64'd0);
        checkOutput("midrst_rready_s0", 64'(RREADY_S0), 64'd0);
        checkOutput("midrst_rdata_m0", 64'(RDATA_M0), 64'd0);
        checkOutput("midrst_state", 64'(dut.state_q), 64'(IDLE));
        sq0.delete();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        applyStimulus(1, 8'h27, 32'hF000_0001, 2'b00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("postrst_rready_s1", 64'(RREADY_S1), 64'd1);
        checkOutput("postrst_rvalid_m1", 64'(RVALID_M1), 64'd1);
        checkOutput("postrst_state", 64'(dut.state_q), 64'(IDLE));
        waitDrain("drain_postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
